cfu_initiator: RTL
==================

CFU_INITIATOR -- requirements
Module: cfu_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles from entering CMD to response before timeout (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state is on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous assert, active-low (0 = in reset), released synchronously by the integrator.
REQ-004 SHALL have ports req_valid/req_ready  input/output  1/1  upstream command handshake.
REQ-005 SHALL have ports req_function_id  input  10  and  req_inputs_0, req_inputs_1  input  32 each  upstream command payload.
REQ-006 SHALL have ports cmd_valid  output  1,  cmd_ready  input  1,  cmd_payload_function_id  output  10,  cmd_payload_inputs_0/1  output  32 each  CFU command channel.
REQ-007 SHALL have ports rsp_valid  input  1,  rsp_ready  output  1,  rsp_payload_outputs_0  input  32  CFU response channel.
REQ-008 SHALL have ports res_valid  output  1,  res_ready  input  1,  res_data  output  32,  res_error  output  1  upstream result handshake.
REQ-009 SHALL have port done_count  output  16  count of results delivered upstream.

Function
REQ-010 SHALL implement states IDLE, CMD, WAIT_RSP, RESULT; one command outstanding at most.
REQ-011 IDLE: req_ready=1; on req_valid&req_ready SHALL latch function_id/inputs into cmd payload registers, clear timeout counter, go CMD.
REQ-012 CMD: cmd_valid=1 with payload held stable until cmd_valid&cmd_ready; rsp_ready=1.
REQ-013 CMD, cmd fire and rsp fire in same cycle (combinational CFU): SHALL capture rsp_payload_outputs_0 into res_data, res_error=0, go RESULT directly.
REQ-014 CMD, cmd fire without rsp fire: go WAIT_RSP; rsp_ready stays 1.
REQ-015 WAIT_RSP: on rsp_valid SHALL capture payload, res_error=0, go RESULT; cmd_valid=0.
REQ-016 RESULT: res_valid=1, res_data/res_error stable; on res_ready go IDLE next cycle; req_ready=0, rsp_ready=0, cmd_valid=0.
REQ-017 rsp_valid in IDLE or RESULT SHALL be ignored (rsp_ready=0); responses never buffered.
REQ-018 done_count SHALL increment by 1 on each res_valid&res_ready, wrapping 0xFFFF->0x0000.
REQ-019 Minimum latency: req accept to res_valid = 2 cycles with a combinational CFU (IDLE->CMD->RESULT).
REQ-020 req_ready, cmd_valid, rsp_ready, res_valid SHALL be registered-state decodes, not combinational paths from any input.

Reset
REQ-021 On reset=0 SHALL immediately force state IDLE, cmd_valid=0, rsp_ready=0, res_valid=0, res_error=0, res_data=0, cmd payloads=0, done_count=0, timeout counter=0; req_ready=1 only after reset deasserts.
REQ-022 Reset in CMD/WAIT_RSP SHALL abandon the command with no result produced.

Configuration
REQ-023 Macro CFU_INITIATOR_TIMEOUT_EN defined: 16-bit counter increments each cycle in CMD/WAIT_RSP; on reaching TIMEOUT_CYCLES without response SHALL go RESULT with res_error=1, res_data=0; cmd_valid drops.
REQ-024 Response fire in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (res_error=0).
REQ-025 Macro undefined: no counter; res_error tied 0; waits indefinitely.

Structure
REQ-026 SHALL place state enum (IDLE, CMD, WAIT_RSP, RESULT), FUNC_ID_W=10, DATA_W=32, CNT_W=16 in shared package cfu_initiator_pkg.
REQ-027 Single module; timeout counter MAY be sub-module cfu_timeout_counter, no other sub-modules.

Verification
REQ-028 Combinational CFU model (out = ~in0 ^ in1, rsp_valid=cmd_valid, cmd_ready=rsp_ready), req in0=0x000000FF, in1=0x0F0F0F0F -> res_data=0xF0F0F00F, res_error=0, res_valid 2 cycles after req accept.
REQ-029 Multi-cycle CFU responding 5 cycles after cmd fire -> state passes through WAIT_RSP, res_data matches, cmd_valid low during wait.
REQ-030 res_ready held 0 for 10 cycles -> res_valid/res_data stable, req_ready=0, done_count unchanged until accept.
REQ-031 TIMEOUT_EN, TIMEOUT_CYCLES=4, CFU never responds -> res_error=1, res_data=0 at 4 cycles; response on the 4th cycle instead -> res_error=0.
REQ-032 reset=0 asserted mid-WAIT_RSP -> all outputs at reset values same cycle, no result; done_count preloaded 0xFFFF plus one result -> 0x0000.

Source files
------------

// File: rtl/cfu_initiator_pkg.sv
// Shared types and widths for the CFU initiator.
package cfu_initiator_pkg;

  localparam int unsigned FUNC_ID_W = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT_RSP,
    RESULT
  } state_e;

endpackage

// File: rtl/cfu_initiator.sv
// Bridges an upstream request/result handshake onto a CFU cmd/rsp channel, one command at a time.
// Optional response timeout is enabled by defining CFU_INITIATOR_TIMEOUT_EN.
module cfu_initiator
  import cfu_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FUNC_ID_W-1:0] req_function_id,
  input  logic [DATA_W-1:0]    req_inputs_0,
  input  logic [DATA_W-1:0]    req_inputs_1,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [FUNC_ID_W-1:0] cmd_payload_function_id,
  output logic [DATA_W-1:0]    cmd_payload_inputs_0,
  output logic [DATA_W-1:0]    cmd_payload_inputs_1,
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic [DATA_W-1:0]    rsp_payload_outputs_0,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic                 res_error,
  output logic [CNT_W-1:0]     done_count
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cfu_initiator: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e               state_q, state_d;
  logic                 run_q;
  logic [FUNC_ID_W-1:0] fid_q;
  logic [DATA_W-1:0]    in0_q, in1_q, res_data_q;
  logic [CNT_W-1:0]     done_count_q;
  logic                 busy, req_fire, cmd_fire, rsp_take, timeout_hit, res_fire, expire;

  assign busy        = (state_q == CMD) || (state_q == WAIT_RSP);
  assign req_fire    = req_valid && req_ready;
  assign cmd_fire    = cmd_valid && cmd_ready;
  // In CMD a response only counts when the command is accepted in the same cycle.
  assign rsp_take    = ((state_q == CMD) && cmd_fire && rsp_valid) ||
                       ((state_q == WAIT_RSP) && rsp_valid);
  assign timeout_hit = expire && !rsp_take;
  assign res_fire    = res_valid && res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_fire) state_d = CMD;
      CMD: begin
        if (rsp_take || timeout_hit) state_d = RESULT;
        else if (cmd_fire)           state_d = WAIT_RSP;
      end
      WAIT_RSP: if (rsp_take || timeout_hit) state_d = RESULT;
      RESULT:   if (res_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // run_q keeps req_ready low until the first clock after reset release.
  always_comb begin
    req_ready = (state_q == IDLE) && run_q;
    cmd_valid = (state_q == CMD);
    rsp_ready = busy;
    res_valid = (state_q == RESULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q        <= 1'b0;
      fid_q        <= '0;
      in0_q        <= '0;
      in1_q        <= '0;
      res_data_q   <= '0;
      done_count_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (req_fire) begin
        fid_q <= req_function_id;
        in0_q <= req_inputs_0;
        in1_q <= req_inputs_1;
      end
      if (rsp_take)         res_data_q <= rsp_payload_outputs_0;
      else if (timeout_hit) res_data_q <= '0;
      if (res_fire) done_count_q <= done_count_q + 1'b1;
    end
  end

`ifdef CFU_INITIATOR_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             res_error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q   <= '0;
      res_error_q <= 1'b0;
    end else begin
      if (req_fire)  tmo_cnt_q <= '0;
      else if (busy) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (rsp_take)         res_error_q <= 1'b0;
      else if (timeout_hit) res_error_q <= 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th cycle spent in CMD/WAIT_RSP.
  assign expire    = busy && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign res_error = res_error_q;
`else
  assign expire    = 1'b0;
  assign res_error = 1'b0;
`endif

  assign cmd_payload_function_id = fid_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;
  assign res_data                = res_data_q;
  assign done_count              = done_count_q;

endmodule
